// File: rtl/axi4_lite_sub_if.sv
// AXI4-Lite bundle shared by the register subordinate and whatever manager drives it.
interface axi4_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] awaddr;
  logic                  awvalid;
  logic                  awready;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic                  arvalid;
  logic                  arready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  modport subordinate (
    input  awaddr, awvalid, wdata, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport manager (
    output awaddr, awvalid, wdata, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi4_lite_sub.sv
// AXI4-Lite subordinate with four read/write registers at 0x00..0x0C.
// Define AXI4_LITE_SUB_DECERR_EN to answer addresses >= 0x10 with SLVERR instead of aliasing.
module axi4_lite_sub #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic aclk,
  input  logic aresetn,
  axi4_if.subordinate s_axi
);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic [DATA_WIDTH-1:0] regs [4];

  logic                  ready_en;
  logic                  aw_held;
  logic                  w_held;
  logic [ADDR_WIDTH-1:0] aw_addr_q;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic                  bvalid_q;
  logic [1:0]            bresp_q;
  logic                  rvalid_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [1:0]            rresp_q;

  logic                  aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic                  do_write;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_err, rd_err;

  // Readies stay low during reset and rise on the first edge after release.
  assign s_axi.awready = ready_en & ~aw_held & ~bvalid_q;
  assign s_axi.wready  = ready_en & ~w_held  & ~bvalid_q;
  assign s_axi.arready = ready_en & ~rvalid_q;
  assign s_axi.bvalid  = bvalid_q;
  assign s_axi.bresp   = bresp_q;
  assign s_axi.rvalid  = rvalid_q;
  assign s_axi.rdata   = rdata_q;
  assign s_axi.rresp   = rresp_q;

  assign aw_hs = s_axi.awvalid & s_axi.awready;
  assign w_hs  = s_axi.wvalid  & s_axi.wready;
  assign b_hs  = bvalid_q      & s_axi.bready;
  assign ar_hs = s_axi.arvalid & s_axi.arready;
  assign r_hs  = rvalid_q      & s_axi.rready;

  // A write fires on whichever edge completes the address/data pair.
  assign wr_addr  = aw_held ? aw_addr_q : s_axi.awaddr;
  assign wr_data  = w_held  ? w_data_q  : s_axi.wdata;
  assign do_write = (aw_held | aw_hs) & (w_held | w_hs) & ~bvalid_q;

`ifdef AXI4_LITE_SUB_DECERR_EN
  assign wr_err = |wr_addr[ADDR_WIDTH-1:4];
  assign rd_err = |s_axi.araddr[ADDR_WIDTH-1:4];
  logic unused_addr_bits;
  assign unused_addr_bits = ^{wr_addr[1:0], s_axi.araddr[1:0]};
`else
  assign wr_err = 1'b0;
  assign rd_err = 1'b0;
  logic unused_addr_bits;
  assign unused_addr_bits = ^{wr_addr[ADDR_WIDTH-1:4], wr_addr[1:0],
                              s_axi.araddr[ADDR_WIDTH-1:4], s_axi.araddr[1:0]};
`endif

  // NOTE: the register file is reset explicitly because software relies on it reading zero
  // after reset; with only four words the reset fan-out is negligible.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < 4; i++) regs[i] <= '0;
    end else if (do_write && !wr_err) begin
      regs[wr_addr[3:2]] <= wr_data;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ready_en  <= 1'b0;
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
    end else begin
      ready_en <= 1'b1;
      if (b_hs) begin
        bvalid_q <= 1'b0;
        aw_held  <= 1'b0;
        w_held   <= 1'b0;
      end else begin
        if (aw_hs) begin
          aw_held   <= 1'b1;
          aw_addr_q <= s_axi.awaddr;
        end
        if (w_hs) begin
          w_held   <= 1'b1;
          w_data_q <= s_axi.wdata;
        end
        if (do_write) begin
          bvalid_q <= 1'b1;
          bresp_q  <= wr_err ? RESP_SLVERR : RESP_OKAY;
        end
      end
    end
  end

  // NOTE: non-blocking assignment means a read on the same edge as a write to the
  // same register samples the old contents, which is the intended ordering.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
    end else if (ar_hs) begin
      rvalid_q <= 1'b1;
      rdata_q  <= rd_err ? '0 : regs[s_axi.araddr[3:2]];
      rresp_q  <= rd_err ? RESP_SLVERR : RESP_OKAY;
    end else if (r_hs) begin
      rvalid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axi4_lite_sub.sv
// Directed bench for axi4_lite_sub: a register-array model predicts every response,
// and a negedge monitor checks handshakes, hold stability and spurious responses.
`timescale 1ns/1ps
module tb_axi4_lite_sub;
  localparam int AW = 32;
  localparam int DW = 32;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  axi4_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  axi4_lite_sub #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .aclk   (aclk),
    .aresetn(aresetn),
    .s_axi  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Behavioural model: the four registers plus queues of outstanding responses.
  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } rexp_t;

  logic [31:0] model [4];
  rexp_t       exp_r [$];
  logic [1:0]  exp_b [$];

  function automatic logic out_of_range(input logic [31:0] addr);
`ifdef AXI4_LITE_SUB_DECERR_EN
    return addr >= 32'h10;
`else
    return (addr == 32'hFFFF_FFFF) && (addr != 32'hFFFF_FFFF);
`endif
  endfunction

  function automatic logic [1:0] model_write(input logic [31:0] addr, input logic [31:0] data);
    if (out_of_range(addr)) return 2'b10;
    model[addr[3:2]] = data;
    return 2'b00;
  endfunction

  function automatic rexp_t model_read(input logic [31:0] addr);
    rexp_t e;
    if (out_of_range(addr)) begin
      e.data = 32'h0;
      e.resp = 2'b10;
    end else begin
      e.data = model[addr[3:2]];
      e.resp = 2'b00;
    end
    return e;
  endfunction

  // Monitor: responses must match the model and stay frozen until accepted.
  logic [31:0] last_rdata;
  logic [1:0]  last_rresp;
  logic [1:0]  last_bresp;
  logic        prev_bpend, prev_rpend;
  logic [1:0]  prev_bresp, prev_rresp;
  logic [31:0] prev_rdata;

  always @(negedge aclk) begin
    if (!aresetn) begin
      prev_bpend = 1'b0;
      prev_rpend = 1'b0;
    end else begin
      if (prev_bpend) begin
        check("bvalid_hold", {31'b0, bus.bvalid}, 32'd1);
        check("bresp_hold", {30'b0, bus.bresp}, {30'b0, prev_bresp});
      end
      if (prev_rpend) begin
        check("rvalid_hold", {31'b0, bus.rvalid}, 32'd1);
        check("rdata_hold", bus.rdata, prev_rdata);
        check("rresp_hold", {30'b0, bus.rresp}, {30'b0, prev_rresp});
      end
      if (bus.bvalid) begin
        if (exp_b.size() == 0) fail_now("bvalid_spurious");
        else if (bus.bready) begin
          check("bresp", {30'b0, bus.bresp}, {30'b0, exp_b.pop_front()});
          last_bresp = bus.bresp;
        end
      end
      if (bus.rvalid) begin
        if (exp_r.size() == 0) fail_now("rvalid_spurious");
        else if (bus.rready) begin
          rexp_t e;
          e = exp_r.pop_front();
          check("rdata", bus.rdata, e.data);
          check("rresp", {30'b0, bus.rresp}, {30'b0, e.resp});
          last_rdata = bus.rdata;
          last_rresp = bus.rresp;
        end
      end
      prev_bpend = bus.bvalid && !bus.bready;
      prev_bresp = bus.bresp;
      prev_rpend = bus.rvalid && !bus.rready;
      prev_rresp = bus.rresp;
      prev_rdata = bus.rdata;
    end
  end

  // Write with independent AW/W launch delays and a bready stall.
  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] resp,
                           input int aw_dly, input int w_dly, input int b_dly);
    bit ok;
    exp_b.push_back(resp);
    fork
      begin
        bit got;
        got = 1'b0;
        repeat (aw_dly + 1) @(posedge aclk);
        #1 bus.awaddr = addr; bus.awvalid = 1'b1;
        for (int i = 0; i < 50 && !got; i++) begin
          @(negedge aclk); got = bus.awready;
          @(posedge aclk); #1;
        end
        bus.awvalid = 1'b0;
        if (!got) fail_now("aw_timeout");
      end
      begin
        bit got;
        got = 1'b0;
        repeat (w_dly + 1) @(posedge aclk);
        #1 bus.wdata = data; bus.wvalid = 1'b1;
        for (int i = 0; i < 50 && !got; i++) begin
          @(negedge aclk); got = bus.wready;
          @(posedge aclk); #1;
        end
        bus.wvalid = 1'b0;
        if (!got) fail_now("w_timeout");
      end
    join
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge aclk); ok = bus.bvalid;
    end
    if (!ok) begin
      fail_now("b_timeout");
      void'(exp_b.pop_back());
    end else begin
      repeat (b_dly) @(posedge aclk);
      @(posedge aclk); #1 bus.bready = 1'b1;
      @(posedge aclk); #1 bus.bready = 1'b0;
    end
  endtask

  task automatic bus_read(input logic [31:0] addr, input rexp_t e, input int r_dly);
    bit ok;
    bit got;
    exp_r.push_back(e);
    got = 1'b0;
    @(posedge aclk);
    #1 bus.araddr = addr; bus.arvalid = 1'b1;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge aclk); got = bus.arready;
      @(posedge aclk); #1;
    end
    bus.arvalid = 1'b0;
    if (!got) fail_now("ar_timeout");
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge aclk); ok = bus.rvalid;
    end
    if (!ok) begin
      fail_now("r_timeout");
      void'(exp_r.pop_back());
    end else begin
      repeat (r_dly) @(posedge aclk);
      @(posedge aclk); #1 bus.rready = 1'b1;
      @(posedge aclk); #1 bus.rready = 1'b0;
    end
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    bus_write(addr, data, model_write(addr, data), 0, 0, 0);
  endtask

  task automatic rd_lit(input logic [31:0] addr, input logic [31:0] lit, input int r_dly);
    bus_read(addr, model_read(addr), r_dly);
    check($sformatf("lit_rd_%0h", addr), last_rdata, lit);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_awready"}, {31'b0, bus.awready}, 32'd0);
    check({tag, "_wready"},  {31'b0, bus.wready},  32'd0);
    check({tag, "_arready"}, {31'b0, bus.arready}, 32'd0);
    check({tag, "_bvalid"},  {31'b0, bus.bvalid},  32'd0);
    check({tag, "_rvalid"},  {31'b0, bus.rvalid},  32'd0);
    check({tag, "_rdata"},   bus.rdata, 32'd0);
    check({tag, "_resps"},   {28'b0, bus.bresp, bus.rresp}, 32'd0);
  endtask

  task automatic apply_reset(input int hold_ns);
    aresetn = 1'b0;
    bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
    bus.bready  = 1'b0; bus.rready = 1'b0;
    exp_b.delete();
    exp_r.delete();
    foreach (model[i]) model[i] = 32'h0;
    #1 check_reset_outputs("rst_enter");
    #(hold_ns);
    check_reset_outputs("rst_hold");
    @(negedge aclk) aresetn = 1'b1;
    #1 check("ready_before_edge", {31'b0, bus.awready}, 32'd0);
    @(negedge aclk);
    check("awready_after_rst", {31'b0, bus.awready}, 32'd1);
    check("wready_after_rst",  {31'b0, bus.wready},  32'd1);
    check("arready_after_rst", {31'b0, bus.arready}, 32'd1);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wvalid = 1'b0;
    bus.bready = 1'b0; bus.araddr = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
    apply_reset(100);

    // Basic write/read-back on REG0 and REG1.
    rd_lit(32'h00, 32'h0000_0000, 0);
    wr(32'h00, 32'hDEAD_BEEF);
    rd_lit(32'h00, 32'hDEAD_BEEF, 0);
    rd_lit(32'h04, 32'h0000_0000, 0);
    wr(32'h04, 32'hADAD_ABAB);
    rd_lit(32'h04, 32'hADAD_ABAB, 0);
    rd_lit(32'h00, 32'hDEAD_BEEF, 0);

    // Low address bits ignored; AW ahead of W; slow rready.
    bus_write(32'h0F, 32'h0BAD_F00D, model_write(32'h0F, 32'h0BAD_F00D), 0, 2, 0);
    rd_lit(32'h0C, 32'h0BAD_F00D, 4);

    // Reset while a write response is pending: response dropped, registers cleared.
    exp_b.push_back(model_write(32'h08, 32'h5555_AAAA));
    @(posedge aclk);
    #1 bus.awaddr = 32'h08; bus.awvalid = 1'b1; bus.wdata = 32'h5555_AAAA; bus.wvalid = 1'b1;
    @(posedge aclk);
    #1 bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    @(negedge aclk);
    check("bvalid_before_abort", {31'b0, bus.bvalid}, 32'd1);
    apply_reset(20000);
    rd_lit(32'h00, 32'h0000_0000, 0);
    rd_lit(32'h04, 32'h0000_0000, 0);
    rd_lit(32'h08, 32'h0000_0000, 0);
    wr(32'h00, 32'hBEBE_BABA);
    wr(32'h04, 32'hDADA_BBBB);
    rd_lit(32'h00, 32'hBEBE_BABA, 0);
    rd_lit(32'h04, 32'hDADA_BBBB, 0);

    // Read and write of REG2 handshaking on the same edge: read sees the old value.
    begin
      rexp_t re;
      logic [1:0] wresp;
      re    = model_read(32'h08);
      wresp = model_write(32'h08, 32'h1234_5678);
      fork
        bus_read(32'h08, re, 0);
        bus_write(32'h08, 32'h1234_5678, wresp, 0, 0, 0);
      join
      check("same_edge_rd", last_rdata, 32'h0000_0000);
    end
    rd_lit(32'h08, 32'h1234_5678, 0);

    // W three cycles before AW, bready stalled five cycles; no repeated response.
    bus_write(32'h0C, 32'hCAFE_F00D, model_write(32'h0C, 32'hCAFE_F00D), 3, 0, 5);
    repeat (5) @(posedge aclk);
    rd_lit(32'h0C, 32'hCAFE_F00D, 0);

    // Read channel runs while a write response is stalled.
    begin
      rexp_t re;
      logic [1:0] wresp;
      wresp = model_write(32'h04, 32'h0F0F_0F0F);
      re    = model_read(32'h00);
      fork
        bus_write(32'h04, 32'h0F0F_0F0F, wresp, 0, 0, 6);
        bus_read(32'h00, re, 0);
      join
    end
    rd_lit(32'h04, 32'h0F0F_0F0F, 0);

    // Out-of-range access: SLVERR with the decode check, aliasing onto REG0 without it.
    wr(32'h10, 32'hFFFF_FFFF);
`ifdef AXI4_LITE_SUB_DECERR_EN
    check("oor_bresp", {30'b0, last_bresp}, 32'd2);
    rd_lit(32'h10, 32'h0000_0000, 0);
    check("oor_rresp", {30'b0, last_rresp}, 32'd2);
    rd_lit(32'h00, 32'hBEBE_BABA, 0);
`else
    check("oor_bresp", {30'b0, last_bresp}, 32'd0);
    rd_lit(32'h10, 32'hFFFF_FFFF, 0);
    check("oor_rresp", {30'b0, last_rresp}, 32'd0);
    rd_lit(32'h00, 32'hFFFF_FFFF, 0);
`endif

    repeat (4) @(posedge aclk);
    check("b_queue_drained", exp_b.size(), 32'd0);
    check("r_queue_drained", exp_r.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
